axis_gen_sequencer: RTL and testbench

Run-level controller for the simple AXI-stream frame generator. It latches a run configuration, issues one trigger pulse per frame to the generator, and watches the generator's output stream for frame-end handshakes. Between frames it inserts a programmable idle gap, and it reports progress, completion and errors. It sits beside the generator in test and bring-up designs, replacing free-running `gen_en` operation with counted, gapped frame runs.

---
 rtl/axis_gen_sequencer_pkg.sv | 17 +
 rtl/axis_gen_sequencer_if.sv | 10 +
 rtl/axis_gen_sequencer.sv | 125 ++++++++++++
 tb/tb_axis_gen_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_sequencer_pkg.sv
// Shared types and helpers for the frame-run sequencer.
package axis_gen_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LAST,
        GAP,
        DONE
    } SEQ_STATE;

    // A transfer only counts when the stream clock enable is also high.
    function automatic logic axis_beat(input logic valid, input logic ready, input logic aclken);
        return valid & ready & aclken;
    endfunction

endpackage

// File: rtl/axis_gen_sequencer_if.sv
// Passive tap of the generator output stream.
interface axis_gen_sequencer_if;
    logic mon_tvalid;
    logic mon_tready;
    logic mon_tlast;
    logic mon_aclken;

    modport master (output mon_tvalid, output mon_tready, output mon_tlast, output mon_aclken);
    modport slave  (input  mon_tvalid, input  mon_tready, input  mon_tlast, input  mon_aclken);
endinterface

// File: rtl/axis_gen_sequencer.sv
// Run-level controller: counted, gapped frame runs for the AXI-stream generator.
module axis_gen_sequencer
    import axis_gen_sequencer_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_W-1:0]     cfg_length,
    input  logic [CNT_W-1:0]     cfg_frames,
    input  logic [GAP_W-1:0]     cfg_gap,
    axis_gen_sequencer_if.slave  mon,
    output logic                 gen_trigger,
    output logic [LEN_W-1:0]     gen_length,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     frames_done
);

    localparam int TO_W  = $clog2(TIMEOUT);
    localparam int TMR_W = (GAP_W > TO_W) ? GAP_W : TO_W;

    SEQ_STATE         state_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] frames_q;
    logic [GAP_W-1:0] gap_q;
    logic [LEN_W-1:0] beat_q;
    logic [CNT_W-1:0] fd_q;
    logic             err_q;
    logic [TMR_W-1:0] tmr_q;

    // Incremented copies of the counters and stream qualifiers.
    logic [LEN_W-1:0] beat_d;
    logic [CNT_W-1:0] fd_d;
    logic [TMR_W-1:0] tmr_d;
    logic [GAP_W-1:0] gap_m1;
    logic             beat;
    logic             last;

    assign beat_d = beat_q + LEN_W'(1);
    assign fd_d   = fd_q + CNT_W'(1);
    assign tmr_d  = tmr_q + TMR_W'(1);
    assign gap_m1 = gap_q - GAP_W'(1);
    assign beat   = axis_beat(mon.mon_tvalid, mon.mon_tready, mon.mon_aclken);
    assign last   = beat & mon.mon_tlast;

    // Run FSM; the single timer serves both the gap count and the Last timeout.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            frames_q <= '0;
            gap_q    <= '0;
            beat_q   <= '0;
            fd_q     <= '0;
            err_q    <= 1'b0;
            tmr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // abort in IDLE suppresses the run request entirely
                    if (start && !abort) begin
                        if (cfg_length > LEN_W'(1)) begin
                            len_q    <= cfg_length;
                            frames_q <= cfg_frames;
                            gap_q    <= cfg_gap;
                            err_q    <= 1'b0;
                            fd_q     <= '0;
                            beat_q   <= '0;
                            state_q  <= ARM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ARM: begin
                    beat_q  <= '0;
                    tmr_q   <= '0;
                    state_q <= abort ? IDLE : WAIT_LAST;
                end
                WAIT_LAST: begin
                    if (beat) beat_q <= beat_d;
                    if (last) begin
                        // a frame that ends still counts, even when aborted in the same cycle
                        fd_q  <= fd_d;
                        tmr_q <= '0;
                        if (beat_d != len_q) err_q <= 1'b1;
                        if (abort)                                state_q <= IDLE;
                        else if (frames_q != '0 && fd_d == frames_q) state_q <= DONE;
                        else if (gap_q != '0)                     state_q <= GAP;
                        else                                      state_q <= ARM;
                    end else if (abort) begin
                        state_q <= IDLE;
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                GAP: begin
                    if (abort)                        state_q <= IDLE;
                    else if (tmr_q == TMR_W'(gap_m1)) state_q <= ARM;
                    else                              tmr_q   <= tmr_d;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gen_trigger = (state_q == ARM);
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign gen_length  = len_q;
    assign frames_done = fd_q;
    assign err         = err_q;

endmodule

// File: tb/tb_axis_gen_sequencer.sv
// Randomized scoreboard bench for axis_gen_sequencer (TIMEOUT shortened to 16).
module tb_axis_gen_sequencer;

    localparam int LEN_W = 16;
    localparam int CNT_W = 8;
    localparam int GAP_W = 16;
    localparam int TO    = 16;
    localparam int K_TRIG = 0, K_DONE = 1, K_END = 2;

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] cfg_length = '0;
    logic [CNT_W-1:0] cfg_frames = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic             gen_trigger, busy, done, err;
    logic [LEN_W-1:0] gen_length;
    logic [CNT_W-1:0] frames_done;

    axis_gen_sequencer_if mon_if();

    axis_gen_sequencer #(.LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W), .TIMEOUT(TO)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_length(cfg_length), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
        .mon(mon_if), .gen_trigger(gen_trigger), .gen_length(gen_length),
        .busy(busy), .done(done), .err(err), .frames_done(frames_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct { int kind; int cyc; int fd; int er; int len; } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int kind, input int c, input int fd, input int er, input int len);
        ev_t e;
        e.kind = kind; e.cyc = c; e.fd = fd; e.er = er; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic pop_ev(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind == K_TRIG) chk("gen_length", int'(gen_length), e.len);
        else begin
            chk("frames_done", int'(frames_done), e.fd);
            chk("err", int'(err), e.er);
        end
    endtask

    // Monitor: every trigger, done pulse and busy fall must match the next expected event.
    logic busy_prev = 1'b0;
    always @(negedge clock) begin
        if (gen_trigger) pop_ev(K_TRIG);
        if (done) pop_ev(K_DONE);
        if (busy_prev && !busy) pop_ev(K_END);
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // 0 noise, 1 beat, 2 last beat, 3 non-beat, 4 anything but a Last
    task automatic set_bus(input int mode);
        logic v, r, a, l;
        v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
        a = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1));
        case (mode)
            1: begin v = 1; r = 1; a = 1; l = 0; end
            2: begin v = 1; r = 1; a = 1; l = 1; end
            3: if (v && r && a) a = 0;
            4: l = 0;
            default: ;
        endcase
        mon_if.mon_tvalid = v; mon_if.mon_tready = r;
        mon_if.mon_aclken = a; mon_if.mon_tlast = l;
    endtask

    task automatic rand_cfg();
        cfg_length = LEN_W'($urandom_range(0, 9));
        cfg_frames = CNT_W'($urandom_range(0, 5));
        cfg_gap    = GAP_W'($urandom_range(0, 4));
    endtask

    // One run: plan the whole cycle schedule, queue the expected events, then drive.
    task automatic run(input int len, input int frames, input int gap, input int kmax,
                       input int amode, input int to_frame, input int mis_frame, input int mis_n);
        int sched[$];
        int T, trig, W, H, nfr, nb;
        int errx;
        tick();
        T = cyc;
        start = 1; abort = 0;
        cfg_length = LEN_W'(len); cfg_frames = CNT_W'(frames); cfg_gap = GAP_W'(gap);
        set_bus(0);
        nfr  = (frames != 0) ? frames : kmax;
        trig = T + 1;
        errx = 0;
        for (int k = 0; k < nfr; k++) begin
            push(K_TRIG, trig, 0, 0, len);
            sched.push_back(0);
            W = trig + 1;
            if (k == to_frame) begin
                repeat (TO) sched.push_back(4);
                push(K_END, W + TO, k, 1, 0);
                break;
            end
            nb = (k == mis_frame) ? mis_n : len;
            if (nb != len) errx = 1;
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 2) == 0) sched.push_back(3);
                sched.push_back((i == nb - 1) ? 2 : 1);
            end
            H = T + sched.size();
            if (frames != 0 && k == frames - 1) begin
                push(K_DONE, H + 1, k + 1, errx, 0);
                push(K_END, H + 2, k + 1, errx, 0);
                sched.push_back(0);
            end else if (frames == 0 && k == kmax - 1) begin
                if (amode == 1) begin
                    sched[sched.size() - 1] += 8;
                    push(K_END, H + 1, k + 1, errx, 0);
                end else begin
                    if (gap == 0) push(K_TRIG, H + 1, 0, 0, len);
                    sched.push_back(8);
                    push(K_END, H + 2, k + 1, errx, 0);
                end
            end else begin
                repeat (gap) sched.push_back(0);
                trig = H + 1 + gap;
            end
        end
        foreach (sched[i]) begin
            tick();
            start = 0;
            abort = (sched[i] >= 8);
            set_bus(sched[i] % 8);
            rand_cfg();
        end
        repeat (3) begin
            tick();
            abort = 0;
            set_bus(0);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int T;
        set_bus(0);
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_trigger", int'(gen_trigger), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_frames_done", int'(frames_done), 0);
        chk("rst_gen_length", int'(gen_length), 0);
        rst_n = 1;
        tick();

        run(4, 3, 2, 0, 0, -1, -1, 0);   // basic counted run
        run(3, 2, 0, 0, 0, -1, -1, 0);   // zero gap
        run(4, 1, 0, 0, 0, 0, -1, 0);    // timeout on first frame
        run(4, 3, 1, 0, 0, 1, -1, 0);    // timeout on a later frame
        run(3, 0, 1, 5, 2, -1, -1, 0);   // continuous, abort in gap after 5 frames
        run(3, 0, 0, 2, 1, -1, -1, 0);   // abort together with Last
        run(5, 2, 1, 0, 0, -1, 0, 3);    // short frame: err but run completes

        // illegal length: error only, no run
        tick(); start = 1; cfg_length = 1;
        tick(); start = 0;
        chk("badlen_err", int'(err), 1);
        chk("badlen_busy", int'(busy), 0);
        tick();
        chk("badlen_busy_later", int'(busy), 0);

        // abort beats start in IDLE; err remains from before
        tick(); start = 1; abort = 1; cfg_length = 4; cfg_frames = 1;
        tick(); start = 0; abort = 0;
        chk("abort_start_busy", int'(busy), 0);
        chk("abort_start_err", int'(err), 1);

        for (int r = 0; r < 25; r++) begin
            int len, frames, gap, kmax, amode, nfr, tof, mis, misn;
            len    = $urandom_range(2, 6);
            frames = $urandom_range(0, 4);
            gap    = $urandom_range(0, 3);
            kmax   = $urandom_range(1, 4);
            amode  = $urandom_range(1, 2);
            nfr    = (frames != 0) ? frames : kmax;
            tof    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, nfr - 1)) : -1;
            mis    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nfr - 1)) : -1;
            if (frames == 0 && amode == 1 && mis == kmax - 1) mis = -1;
            misn   = (len == 2) ? 3 : len - 1;
            run(len, frames, gap, kmax, amode, tof, mis, misn);
        end

        // reset in the middle of a run
        tick(); T = cyc;
        start = 1; cfg_length = 3; cfg_frames = 0; cfg_gap = 1; set_bus(0);
        push(K_TRIG, T + 1, 0, 0, 3);
        push(K_TRIG, T + 5, 0, 0, 3);
        push(K_END, T + 7, 0, 0, 0);
        tick(); start = 0; set_bus(0);   // ARM
        tick(); set_bus(1);              // WAIT_LAST
        tick(); set_bus(2);              // Last after 2 beats of 3
        tick(); set_bus(0);              // GAP
        tick(); set_bus(0);              // ARM
        chk("midrun_err", int'(err), 1);
        chk("midrun_frames_done", int'(frames_done), 1);
        tick(); set_bus(1); rst_n = 0;
        tick();
        chk("rst2_gen_length", int'(gen_length), 0);
        chk("rst2_err", int'(err), 0);
        chk("rst2_frames_done", int'(frames_done), 0);
        chk("rst2_trigger", int'(gen_trigger), 0);
        chk("rst2_done", int'(done), 0);
        rst_n = 1;
        repeat (3) tick();
        chk("final_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
